// File: rtl/signal_conflict_monitor.sv
// Safety stage behind the signal controller: checks lamp buses for illegal
// states and drives either a registered pass-through or a red fail-safe.
module signal_conflict_monitor #(
    parameter int FAULT_PERSIST = 3,
    parameter int WDOG_MAX      = 32,
    parameter int FLASH_HALF    = 4,
    parameter int ALL_RED       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] in_RS,
    input  logic [2:0] in_RD,
    input  logic [2:0] in_RT,
    input  logic [2:0] in_LD,
    input  logic       fault_clr,
    output logic [2:0] out_RS,
    output logic [2:0] out_RD,
    output logic [2:0] out_RT,
    output logic [2:0] out_LD,
    output logic       fault,
    output logic [3:0] fault_code
);

    localparam int PW = $clog2(FAULT_PERSIST + 1);
    localparam int WW = $clog2(WDOG_MAX + 1);
    localparam int FW = $clog2(2 * FLASH_HALF + 1);
    localparam int RW = $clog2(ALL_RED + 1);

    localparam logic [2:0]  GRN  = 3'b001;
    localparam logic [2:0]  YEL  = 3'b010;
    localparam logic [2:0]  RED  = 3'b100;
    localparam logic [11:0] RED4 = {4{RED}};

    typedef enum logic [1:0] {
        S_RECOVER,
        S_MONITOR,
        S_PENDING,
        S_FAULT
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] pcnt, pcnt_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic [FW-1:0] fcnt, fcnt_n;
    logic [RW-1:0] rcnt, rcnt_n;
    logic [3:0]    shadow, shadow_n, code_n;
    logic [11:0]   lamp_in, lamp_prev, lamp_n;
    logic          fault_n;
    logic          enc, conf, skip, wdog, same;
    logic [3:0]    ec;

    function automatic logic is_bad(input logic [2:0] v);
        return !(v == GRN || v == YEL || v == RED);
    endfunction

    function automatic logic is_lit(input logic [2:0] v);
        return v != RED;
    endfunction

    function automatic logic skipped(input logic [2:0] p, input logic [2:0] c);
        return p == GRN && c == RED;
    endfunction

    assign lamp_in = {in_RS, in_RD, in_RT, in_LD};

    assign enc = is_bad(in_RS) | is_bad(in_RD) | is_bad(in_RT) | is_bad(in_LD);

    // Only {RS,LD} and {RS,RD} may show right-of-way together
    assign conf = (is_lit(in_RT) &&
                   (is_lit(in_RS) || is_lit(in_RD) || is_lit(in_LD))) ||
                  (is_lit(in_RD) && is_lit(in_LD));

    assign skip = skipped(lamp_prev[11:9], in_RS) |
                  skipped(lamp_prev[8:6],  in_RD) |
                  skipped(lamp_prev[5:3],  in_RT) |
                  skipped(lamp_prev[2:0],  in_LD);

    assign same = lamp_in == lamp_prev;
    assign wdog = wcnt == WW'(WDOG_MAX);
    assign ec   = {2'b00, conf, enc};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_RECOVER;
            pcnt       <= '0;
            wcnt       <= '0;
            fcnt       <= '0;
            rcnt       <= '0;
            shadow     <= '0;
            lamp_prev  <= RED4;
            fault      <= 1'b0;
            fault_code <= '0;
            {out_RS, out_RD, out_RT, out_LD} <= RED4;
        end else begin
            state      <= state_n;
            pcnt       <= pcnt_n;
            wcnt       <= wcnt_n;
            fcnt       <= fcnt_n;
            rcnt       <= rcnt_n;
            shadow     <= shadow_n;
            lamp_prev  <= lamp_in;
            fault      <= fault_n;
            fault_code <= code_n;
            {out_RS, out_RD, out_RT, out_LD} <= lamp_n;
        end
    end

    always_comb begin
        state_n  = state;
        pcnt_n   = pcnt;
        wcnt_n   = '0;
        fcnt_n   = '0;
        rcnt_n   = rcnt;
        shadow_n = shadow;
        code_n   = fault_code;
        lamp_n   = RED4;
        unique case (state)
            S_MONITOR: begin
                wcnt_n = same ? (wdog ? wcnt : wcnt + WW'(1)) : '0;
                if (skip || wdog || ((enc || conf) && FAULT_PERSIST == 1)) begin
                    state_n = S_FAULT;
                    code_n  = {wdog, skip, conf, enc};
                    fcnt_n  = FW'(1);
                end else if (enc || conf) begin
                    state_n  = S_PENDING;
                    pcnt_n   = PW'(1);
                    shadow_n = ec;
                end else begin
                    lamp_n = lamp_in;
                end
            end
            S_PENDING: begin
                if (enc || conf) begin
                    shadow_n = shadow | ec;
                    if (pcnt == PW'(FAULT_PERSIST - 1)) begin
                        state_n  = S_FAULT;
                        code_n   = shadow | ec;
                        fcnt_n   = FW'(1);
                        pcnt_n   = '0;
                        shadow_n = '0;
                    end else begin
                        pcnt_n = pcnt + PW'(1);
                    end
                end else begin
                    state_n  = S_MONITOR;
                    pcnt_n   = '0;
                    shadow_n = '0;
                end
            end
            S_FAULT: begin
                code_n = fault_code | {1'b0, skip, conf, enc};
                lamp_n = (fcnt < FW'(FLASH_HALF)) ? RED4 : '0;
                fcnt_n = (fcnt == FW'(2 * FLASH_HALF - 1)) ? '0 : fcnt + FW'(1);
                if (fault_clr && !enc && !conf) begin
                    state_n = S_RECOVER;
                    code_n  = '0;
                    rcnt_n  = '0;
                    fcnt_n  = '0;
                    lamp_n  = RED4;
                end
            end
            S_RECOVER: begin
                if (!enc && !conf) begin
                    if (rcnt == RW'(ALL_RED - 1)) begin
                        state_n = S_MONITOR;
                        rcnt_n  = '0;
                    end else begin
                        rcnt_n = rcnt + RW'(1);
                    end
                end else begin
                    rcnt_n = '0;
                end
            end
            default: state_n = S_RECOVER;
        endcase
    end

    assign fault_n = state_n == S_FAULT;

endmodule
